regfile_write_buffer: RTL and testbench

- Write-side front end for the 8-entry x 8-bit register file.
- Pipeline stages post register writes through a valid/ready handshake. The block queues them in a small in-order FIFO and drains one per cycle onto the register file write port (regWrite, writeRegister, writeData).
- Optionally merges pending writes into the two read ports, so readers see the newest value before it is committed.

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/wb_forward_match.sv | 49 ++++
 rtl/regfile_write_buffer.sv | 192 +++++++++++++++++++
 tb/tb_regfile_write_buffer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and types for the 8-entry x 8-bit register file and its
//   write-side buffer.
//
//   REG_ADDR_W  register address width
//   REG_DATA_W  register data width
//   REG_COUNT   number of architectural registers
//   REG_ZERO    hardwired-zero register address (writes to it are dropped)
//   wb_entry_t  one pending write: destination address + data
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int REG_DATA_W = 8;
    localparam int REG_COUNT  = 8;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_forward_match.sv
// -----------------------------------------------------------------------------
// wb_forward_match
//   Combinational youngest-match search over the write buffer entry array.
//   Only instantiated when WB_FORWARD_EN is defined.
//
//   Ports:
//     entries  in   buffer storage, indexed by physical slot
//     valid    in   per-slot valid bits
//     head     in   slot of the oldest pending write
//     count    in   number of pending writes
//     addr     in   register address being read
//     hit      out  a pending write to addr exists
//     data     out  data of the youngest such write (0 when no hit)
// -----------------------------------------------------------------------------
module wb_forward_match
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  wb_entry_t               entries [DEPTH],
    input  logic [DEPTH-1:0]        valid,
    input  logic [PTR_W-1:0]        head,
    input  logic [CNT_W-1:0]        count,
    input  logic [REG_ADDR_W-1:0]   addr,
    output logic                    hit,
    output logic [REG_DATA_W-1:0]   data
);

    logic [PTR_W-1:0] slot;

    // Walk from oldest to youngest; each later match overrides the earlier
    // one, so the result is the youngest match (tail-1 has highest priority).
    always_comb begin
        hit  = 1'b0;
        data = '0;
        slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && valid[slot] &&
                (addr != REG_ZERO) && (entries[slot].addr == addr)) begin
                hit  = 1'b1;
                data = entries[slot].data;
            end
        end
    end

endmodule

// File: rtl/regfile_write_buffer.sv
// -----------------------------------------------------------------------------
// regfile_write_buffer
//   Write-side front end for the register file. Accepts register writes over a
//   valid/ready handshake, queues them in an in-order FIFO and drains one per
//   cycle onto the register file write port. Writes to r0 are acknowledged and
//   dropped.
//
//   Build option:
//     WB_FORWARD_EN  when defined, pending writes are merged into the two read
//                    ports (youngest matching entry wins). When undefined the
//                    read data is a straight pass-through of the register file.
//
//   Ports:
//     clock                  single clock, all state on posedge
//     resetN                 synchronous active-low reset
//     inValid/inReady        write request handshake
//     inRegister, inData     write request destination and data
//     drainHold              suppress draining this cycle
//     regWrite               register file write enable
//     writeRegister/Data     register file write address and data (head entry)
//     readRegister1/2        read addresses (also routed to the register file)
//     rfReadData1/2          raw register file read data
//     readData1/2            read data with pending writes merged in
//     bufEmpty               no pending writes
// -----------------------------------------------------------------------------
module regfile_write_buffer
    import regfile_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              inValid,
    output logic              inReady,
    input  logic [ADDR_W-1:0] inRegister,
    input  logic [DATA_W-1:0] inData,
    input  logic              drainHold,
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeRegister,
    output logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] readRegister1,
    input  logic [ADDR_W-1:0] readRegister2,
    input  logic [DATA_W-1:0] rfReadData1,
    input  logic [DATA_W-1:0] rfReadData2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic              bufEmpty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q,  head_d;
    logic [PTR_W-1:0] tail_q,  tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    wb_entry_t        entries_q [DEPTH];
    wb_entry_t        entries_d [DEPTH];

    logic full;
    logic empty;
    logic accept;
    logic push;
    logic pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // ------------------------------------------------------------------
    // Handshake and drain controls. Reset overrides the status outputs
    // combinationally so nothing is accepted or written while resetN is low.
    // ------------------------------------------------------------------
    always_comb begin
        inReady  = resetN && !full;
        bufEmpty = !resetN || empty;
        regWrite = resetN && !empty && !drainHold;
    end

    assign accept = inValid && inReady;
    // r0 is hardwired zero: the handshake completes but nothing is stored.
    assign push   = accept && (inRegister != ADDR_W'(REG_ZERO));
    assign pop    = regWrite;

    always_comb begin
        writeRegister = entries_q[head_q].addr;
        writeData     = entries_q[head_q].data;
    end

    // ------------------------------------------------------------------
    // Next-state for pointers, occupancy, valid bits and storage.
    // Push never targets the head slot while a pop is in flight: a push
    // needs count < DEPTH and a pop needs count > 0, so tail != head
    // whenever both happen with count > 0, and pop is impossible at 0.
    // ------------------------------------------------------------------
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        valid_d   = valid_q;
        entries_d = entries_q;

        if (push) begin
            entries_d[tail_q] = '{addr: inRegister, data: inData};
            valid_d[tail_q]   = 1'b1;
            tail_d            = tail_q + PTR_W'(1);
        end

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Pending writes are discarded on reset; entry data is left as-is.
        if (!resetN) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
        valid_q <= valid_d;
    end

    // Storage has no reset.
    always_ff @(posedge clock) begin
        entries_q <= entries_d;
    end

    // ------------------------------------------------------------------
    // Read-port merge.
    // ------------------------------------------------------------------
`ifdef WB_FORWARD_EN
    logic              fwd_hit1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data1;
    logic [DATA_W-1:0] fwd_data2;

    wb_forward_match #(
        .DEPTH (DEPTH)
    ) u_match1 (
        .entries (entries_q),
        .valid   (valid_q),
        .head    (head_q),
        .count   (count_q),
        .addr    (readRegister1),
        .hit     (fwd_hit1),
        .data    (fwd_data1)
    );

    wb_forward_match #(
        .DEPTH (DEPTH)
    ) u_match2 (
        .entries (entries_q),
        .valid   (valid_q),
        .head    (head_q),
        .count   (count_q),
        .addr    (readRegister2),
        .hit     (fwd_hit2),
        .data    (fwd_data2)
    );

    // Same-cycle input requests are not considered: only stored entries.
    always_comb begin
        readData1 = fwd_hit1 ? fwd_data1 : rfReadData1;
        readData2 = fwd_hit2 ? fwd_data2 : rfReadData2;
    end
`else
    // Read addresses go straight to the register file; nothing here uses
    // them, nor the per-slot valid bits, without forwarding.
    logic unused_fwd;
    assign unused_fwd = ^{readRegister1, readRegister2, valid_q};

    always_comb begin
        readData1 = rfReadData1;
        readData2 = rfReadData2;
    end
`endif

endmodule

// File: tb/tb_regfile_write_buffer.sv
module tb_regfile_write_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [2:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clock;
    logic       resetN;
    logic       inValid;
    logic       inReady;
    logic [2:0] inRegister;
    logic [7:0] inData;
    logic       drainHold;
    logic       regWrite;
    logic [2:0] writeRegister;
    logic [7:0] writeData;
    logic [2:0] readRegister1;
    logic [2:0] readRegister2;
    logic [7:0] rfReadData1;
    logic [7:0] rfReadData2;
    logic [7:0] readData1;
    logic [7:0] readData2;
    logic       bufEmpty;

    regfile_write_buffer #(
        .DATA_W (8),
        .ADDR_W (3),
        .DEPTH  (DEPTH)
    ) dut (
        .clock         (clock),
        .resetN        (resetN),
        .inValid       (inValid),
        .inReady       (inReady),
        .inRegister    (inRegister),
        .inData        (inData),
        .drainHold     (drainHold),
        .regWrite      (regWrite),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .readRegister1 (readRegister1),
        .readRegister2 (readRegister2),
        .rfReadData1   (rfReadData1),
        .rfReadData2   (rfReadData2),
        .readData1     (readData1),
        .readData2     (readData2),
        .bufEmpty      (bufEmpty)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int  checks = 0;
    int  passes = 0;
    wr_t exp_q[$];    // scoreboard: writes expected on the register file port
    wr_t model_q[$];  // reference contents of the buffer, oldest first
    bit  pin_reads = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Newest pending write to the address wins; r0 and misses read the RF.
    function automatic logic [7:0] fwd_model(input logic [2:0] ra, input logic [7:0] rf);
        logic [7:0] r;
        r = rf;
`ifdef WB_FORWARD_EN
        if (ra != 3'd0)
            foreach (model_q[i])
                if (model_q[i].a == ra) r = model_q[i].d;
`endif
        return r;
    endfunction

    // One clock cycle: drive, check combinational outputs against the model,
    // then advance the model across the posedge.
    task automatic step(input logic v, input logic [2:0] r, input logic [7:0] d,
                        input logic h, input logic rn);
        int   sz;
        logic hs;
        logic pm;
        inValid    = v;
        inRegister = r;
        inData     = d;
        drainHold  = h;
        resetN     = rn;
        if (!pin_reads) begin
            readRegister1 = 3'($urandom_range(0, 7));
            readRegister2 = 3'($urandom_range(0, 7));
            rfReadData1   = 8'($urandom);
            rfReadData2   = 8'($urandom);
        end
        @(negedge clock);
        sz = model_q.size();
        chk("in_ready",   {31'd0, inReady},  {31'd0, (rn && sz != DEPTH)});
        chk("buf_empty",  {31'd0, bufEmpty}, {31'd0, (!rn || sz == 0)});
        chk("reg_write",  {31'd0, regWrite}, {31'd0, (rn && sz != 0 && !h)});
        chk("read_data1", {24'd0, readData1}, {24'd0, fwd_model(readRegister1, rfReadData1)});
        chk("read_data2", {24'd0, readData2}, {24'd0, fwd_model(readRegister2, rfReadData2)});
        hs = v && rn && (sz != DEPTH);
        pm = rn && (sz != 0) && !h;
        @(posedge clock);
        if (!rn) begin
            model_q.delete();
            exp_q.delete();
        end else begin
            if (pm) void'(model_q.pop_front());
            if (hs && r != 3'd0) begin
                model_q.push_back('{a: r, d: d});
                exp_q.push_back('{a: r, d: d});
            end
        end
        #1;
    endtask

    // Monitor: every register file write must be the next expected one.
    initial begin
        wr_t e;
        forever begin
            @(negedge clock);
            if (regWrite === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_write: got r%0d=%0h, expected no write at %0t",
                             writeRegister, writeData, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_register", {29'd0, writeRegister}, {29'd0, e.a});
                    chk("write_data",     {24'd0, writeData},     {24'd0, e.d});
                end
            end
        end
    end

    initial begin
        inValid = 0; inRegister = 0; inData = 0; drainHold = 0; resetN = 0;
        readRegister1 = 0; readRegister2 = 0; rfReadData1 = 0; rfReadData2 = 0;
        @(posedge clock);
        #1;
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 1);

        // Single write r3=0x5A, then drain and empty.
        step(1, 3'd3, 8'h5A, 0, 1);
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 1);

        // Fill with drain held, stall a 5th request, then release.
        for (int i = 1; i <= 4; i++) step(1, 3'(i), 8'(i * 8'h11), 1, 1);
        step(1, 3'd5, 8'h55, 1, 1);
        step(1, 3'd5, 8'h55, 1, 1);
        step(1, 3'd5, 8'h55, 0, 1);
        step(1, 3'd5, 8'h55, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 0, 1);

        // r0 write is acknowledged and dropped.
        step(1, 3'd0, 8'hFF, 0, 1);
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 1);

        // Forwarding of two writes to r2 with drain held.
        pin_reads = 1;
        readRegister1 = 3'd2; rfReadData1 = 8'h00;
        readRegister2 = 3'd5; rfReadData2 = 8'hC3;
        step(1, 3'd2, 8'h10, 1, 1);
        step(1, 3'd2, 8'h20, 1, 1);
        step(0, 0, 8'h00, 1, 1);
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 1);
        pin_reads = 0;

        // Reset with three entries queued: nothing stale may drain.
        step(1, 3'd1, 8'hA1, 1, 1);
        step(1, 3'd6, 8'hA6, 1, 1);
        step(1, 3'd7, 8'hA7, 1, 1);
        step(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0, 1);

        // Back-to-back stream with wrap-around.
        for (int i = 0; i < 10; i++)
            step(1, 3'($urandom_range(1, 7)), 8'($urandom), 0, 1);
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 1);

        // Randomised traffic, occasional holds and resets.
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
                 ($urandom % 4) == 0, ($urandom % 64) != 0);

        for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 0, 1);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
